// File: rtl/shift_add_mult_4bit_pkg.sv
// Shared definitions for the sequential 4x4 shift-add multiplier:
// operand width, iteration count, FSM state encoding and operand gating.
package shift_add_mult_4bit_pkg;

  localparam int WIDTH      = 4;
  localparam int ITERATIONS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Partial-product select: the multiplicand is added only when the
  // current multiplier bit is set.
  function automatic logic [WIDTH-1:0] gate_operand(input logic sel,
                                                    input logic [WIDTH-1:0] m);
    return sel ? m : '0;
  endfunction

endpackage

// File: rtl/shift_add_mult_4bit_if.sv
// Request/response bundle of the multiplier: start with operands in,
// registered product with busy/done status out.
interface shift_add_mult_4bit_if;
  import shift_add_mult_4bit_pkg::*;

  logic                   start;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;
  logic                   done;

  // Requester side.
  modport master (
    output start,
    output a,
    output b,
    input  product,
    input  busy,
    input  done
  );

  // Multiplier side.
  modport slave (
    input  start,
    input  a,
    input  b,
    output product,
    output busy,
    output done
  );

endinterface

// File: rtl/ripple_carry_adder_4bit.sv
// Purely combinational 4-bit ripple-carry adder; one full adder per bit,
// carry chained from bit 0 upward.
module ripple_carry_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [4:0] carry;

  assign carry[0] = c_in;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fa
    assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign c_out = carry[4];

endmodule

// File: rtl/shift_add_mult_4bit.sv
// Sequential 4x4 unsigned multiplier. Each BUSY cycle adds the gated
// multiplicand to the upper half of the accumulator and shifts the 9-bit
// {carry, sum, multiplier} value right by one; after four iterations the
// accumulator holds the 8-bit product.
module shift_add_mult_4bit
  import shift_add_mult_4bit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  shift_add_mult_4bit_if.slave  bus
);

  state_t             state_q,   state_d;
  logic [WIDTH-1:0]   mcand_q,   mcand_d;
  logic [WIDTH-1:0]   acc_hi_q,  acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q,  acc_lo_d;
  logic [2:0]         cnt_q,     cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_c_out;
  logic [2*WIDTH-1:0] shifted;

  // Partial-product adder: acc_hi plus the gated multiplicand, no carry in.
  assign add_b = gate_operand(acc_lo_q[0], mcand_q);

  ripple_carry_adder_4bit u_add (
    .a     (acc_hi_q),
    .b     (add_b),
    .c_in  (1'b0),
    .sum   (add_sum),
    .c_out (add_c_out)
  );

  // The carry lands in the top bit after the shift, so nothing is lost.
  assign shifted = {add_c_out, add_sum, acc_lo_q[WIDTH-1:1]};

  // Next-state, datapath and output decode for the start/busy/done sequencer.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = done_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          mcand_d  = bus.a;
          acc_lo_d = bus.b;
          acc_hi_d = '0;
          cnt_d    = '0;
          state_d  = ST_BUSY;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end else begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b0;
        end
      end

      ST_BUSY: begin
        acc_hi_d = shifted[2*WIDTH-1:WIDTH];
        acc_lo_d = shifted[WIDTH-1:0];
        if (cnt_q == 3'(ITERATIONS - 1)) begin
          product_d = shifted;
          state_d   = ST_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          cnt_d     = cnt_q + 3'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // All state and outputs are registered; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule
